count_direction_decoder: RTL and testbench

//  Recovers the up/down control bit from the 3-bit output stream of the up/down counter.

---
 rtl/cnt_dec_pkg.sv | 29 ++
 rtl/step_classifier.sv | 30 +++
 rtl/count_direction_decoder.sv | 176 +++++++++++++++++
 tb/tb_count_direction_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cnt_dec_pkg.sv
// Shared types for the up/down counter direction decoder.
// Holds the FSM state enum, step class enum and class encodings.
package cnt_dec_pkg;

    localparam logic [1:0] CLS_UP   = 2'd0;
    localparam logic [1:0] CLS_DOWN = 2'd1;
    localparam logic [1:0] CLS_HOLD = 2'd2;
    localparam logic [1:0] CLS_JUMP = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        UP   = CLS_UP,
        DOWN = CLS_DOWN,
        HOLD = CLS_HOLD,
        JUMP = CLS_JUMP
    } cls_t;

    // True for a single-count step in either direction.
    function automatic logic is_step(input cls_t c);
        return (c == UP) || (c == DOWN);
    endfunction

endpackage

// File: rtl/step_classifier.sv
// Combinational step classifier: delta = cnt_in - prev (mod 2**WIDTH).
// Ports: cnt_in, prev (WIDTH) in; cls (cls_t) out.
module step_classifier
    import cnt_dec_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] prev,
    output cls_t             cls
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] delta;

    // Modular subtraction makes wrap (7->0, 0->7) a legal single step.
    assign delta = cnt_in - prev;

    always_comb begin
        cls = JUMP;
        if (delta == ONE)
            cls = UP;
        else if (delta == '1)
            cls = DOWN;
        else if (delta == '0)
            cls = HOLD;
    end

endmodule

// File: rtl/count_direction_decoder.sv
// Recovers the up/down bit from an observed counter stream; locks after
// LOCK_STEPS agreeing steps, faults after ERR_LIMIT bad steps.
// Ports: clk, rst (async high), cnt_in/cnt_vld, resync in;
//        dir, locked, fault, step_cnt, dir_chg out (all registered).
// Build option: DIR_CHG_PULSE_EN enables the dir_chg pulse; else tied 0.
module count_direction_decoder
    import cnt_dec_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int LOCK_STEPS = 2,
    parameter int ERR_LIMIT  = 3,
    parameter int STEP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_vld,
    input  logic              resync,
    output logic              dir,
    output logic              locked,
    output logic              fault,
    output logic [STEP_W-1:0] step_cnt,
    output logic              dir_chg
);

    localparam int RUN_W = $clog2(LOCK_STEPS + 1);
    localparam int BAD_W = $clog2(ERR_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_STEPS);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [BAD_W-1:0] BAD_MAX  = BAD_W'(ERR_LIMIT);
    localparam logic [BAD_W-1:0] BAD_ONE  = BAD_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d, run_nxt;
    logic               run_up_q, run_up_d;
    logic [BAD_W-1:0]   bad_q, bad_d, bad_nxt;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               dir_q, dir_d;
    logic               lock_q, lock_d;
    logic               fault_q, fault_d;
    logic               is_up;
    cls_t               cls;

    step_classifier #(.WIDTH(WIDTH)) u_cls (
        .cnt_in (cnt_in),
        .prev   (prev_q),
        .cls    (cls)
    );

`ifdef DIR_CHG_PULSE_EN
    logic chg_q, chg_d;
`endif

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        run_up_d = run_up_q;
        bad_d    = bad_q;
        step_d   = step_q;
        dir_d    = dir_q;
        lock_d   = lock_q;
        fault_d  = fault_q;
        run_nxt  = run_q;
        bad_nxt  = bad_q + BAD_ONE;
        is_up    = (cls == UP);
`ifdef DIR_CHG_PULSE_EN
        chg_d    = 1'b0;
`endif
        if (resync) begin
            // Restart wins over a same-cycle sample; prev is left alone.
            state_d = IDLE;
            fault_d = 1'b0;
            lock_d  = 1'b0;
            step_d  = '0;
            bad_d   = '0;
            run_d   = '0;
        end else if (cnt_vld) begin
            prev_d = cnt_in;
            unique case (state_q)
                IDLE: begin
                    state_d = ACQ;
                    run_d   = '0;
                end
                ACQ: begin
                    if (is_step(cls)) begin
                        if (run_q != '0 && run_up_q == is_up)
                            run_nxt = run_q + RUN_ONE;
                        else
                            run_nxt = RUN_ONE;
                        run_d    = run_nxt;
                        run_up_d = is_up;
                        if (run_nxt == RUN_LOCK) begin
                            state_d = LOCKED;
                            lock_d  = 1'b1;
                            dir_d   = is_up;
                            step_d  = '0;
                            bad_d   = '0;
                        end
                    end else if (cls == JUMP) begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (is_step(cls) && is_up == dir_q) begin
                        if (step_q != '1)
                            step_d = step_q + STEP_ONE;
                        bad_d = '0;
                    end else if (cls != HOLD) begin
                        // Opposite step flips at once; both it and a
                        // jump count toward the fault limit.
                        bad_d = bad_nxt;
                        if (is_step(cls)) begin
                            dir_d = ~dir_q;
`ifdef DIR_CHG_PULSE_EN
                            chg_d = 1'b1;
`endif
                        end
                        if (bad_nxt == BAD_MAX) begin
                            state_d = FAULT;
                            lock_d  = 1'b0;
                            fault_d = 1'b1;
                        end
                    end
                end
                FAULT: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            run_q    <= '0;
            run_up_q <= 1'b0;
            bad_q    <= '0;
            step_q   <= '0;
            dir_q    <= 1'b0;
            lock_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            run_up_q <= run_up_d;
            bad_q    <= bad_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            lock_q   <= lock_d;
            fault_q  <= fault_d;
        end
    end

`ifdef DIR_CHG_PULSE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            chg_q <= 1'b0;
        else
            chg_q <= chg_d;
    end

    assign dir_chg = chg_q;
`else
    assign dir_chg = 1'b0;
`endif

    assign dir      = dir_q;
    assign locked   = lock_q;
    assign fault    = fault_q;
    assign step_cnt = step_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
// Scoreboard bench for count_direction_decoder (WIDTH=3, LOCK=2, ERR=3).
// Stimulus pushes expected status; a monitor pops after each edge.
module tb_count_direction_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cnt_in;
    logic       cnt_vld;
    logic       resync;
    logic       dir;
    logic       locked;
    logic       fault;
    logic [7:0] step_cnt;
    logic       dir_chg;

`ifdef DIR_CHG_PULSE_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic       dir;
        logic       locked;
        logic       fault;
        logic [7:0] step;
        logic       chg;
        bit         ck_step;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    count_direction_decoder #(
        .WIDTH(3), .LOCK_STEPS(2), .ERR_LIMIT(3), .STEP_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cnt_in),
        .cnt_vld  (cnt_vld),
        .resync   (resync),
        .dir      (dir),
        .locked   (locked),
        .fault    (fault),
        .step_cnt (step_cnt),
        .dir_chg  (dir_chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".locked"}, int'(locked), int'(e.locked));
                chk({e.tag, ".fault"}, int'(fault), int'(e.fault));
                chk({e.tag, ".dir_chg"}, int'(dir_chg), int'(e.chg));
                if (e.locked)
                    chk({e.tag, ".dir"}, int'(dir), int'(e.dir));
                if (e.ck_step)
                    chk({e.tag, ".step"}, int'(step_cnt), int'(e.step));
            end
        end
    end

    task automatic drive(input string tag, input bit v, input int c,
                         input bit rs, input bit el, input bit ef,
                         input bit ed, input int es, input bit ec,
                         input bit cs);
        exp_t e;
        @(negedge clk);
        cnt_vld = v;
        cnt_in  = 3'(c);
        resync  = rs;
        e.tag = tag; e.locked = el; e.fault = ef; e.dir = ed;
        e.step = 8'(es); e.chg = ec; e.ck_step = cs;
        q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        cnt_vld = 1'b0;
        resync  = 1'b0;
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".dir"}, int'(dir), 0);
        chk({nm, ".locked"}, int'(locked), 0);
        chk({nm, ".fault"}, int'(fault), 0);
        chk({nm, ".step"}, int'(step_cnt), 0);
        chk({nm, ".dir_chg"}, int'(dir_chg), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cnt_in = '0; cnt_vld = 1'b0; resync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Acquire upward: lock one cycle after sample 2.
        drive("acq0", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        drive("acq1", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        drive("acq2", 1, 2, 0, 1, 0, 1, 0, 0, 1);
        drive("up3",  1, 3, 0, 1, 0, 1, 1, 0, 1);
        drive("up4",  1, 4, 0, 1, 0, 1, 2, 0, 1);
        drive("up5",  1, 5, 0, 1, 0, 1, 3, 0, 1);
        drive("up6",  1, 6, 0, 1, 0, 1, 4, 0, 1);
        drive("up7",  1, 7, 0, 1, 0, 1, 5, 0, 1);
        drive("wrap0", 1, 0, 0, 1, 0, 1, 6, 0, 1);
        drive("up1",  1, 1, 0, 1, 0, 1, 7, 0, 1);
        // Gaps and repeats leave status unchanged.
        drive("up2",  1, 2, 0, 1, 0, 1, 8, 0, 1);
        drive("hold2a", 1, 2, 0, 1, 0, 1, 8, 0, 1);
        drive("gap",  0, 6, 0, 1, 0, 1, 8, 0, 1);
        drive("hold2b", 1, 2, 0, 1, 0, 1, 8, 0, 1);
        // Direction flip, then recovery downward.
        drive("up3b", 1, 3, 0, 1, 0, 1, 9, 0, 1);
        drive("up4b", 1, 4, 0, 1, 0, 1, 10, 0, 1);
        drive("flip3", 1, 3, 0, 1, 0, 0, 10, CHG_EN, 1);
        drive("dn2",  1, 2, 0, 1, 0, 0, 11, 0, 1);
        drive("dn1",  1, 1, 0, 1, 0, 0, 12, 0, 1);
        // Three jumps force a fault.
        drive("jmp5", 1, 5, 0, 1, 0, 0, 12, 0, 1);
        drive("jmp1", 1, 1, 0, 1, 0, 0, 12, 0, 1);
        drive("jmp5b", 1, 5, 0, 0, 1, 0, 0, 0, 0);
        drive("fltup", 1, 6, 0, 0, 1, 0, 0, 0, 0);
        drive("resync", 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Reacquire downward with wrap 0->7.
        drive("ra3",  1, 3, 0, 0, 0, 0, 0, 0, 1);
        drive("ra2",  1, 2, 0, 0, 0, 0, 0, 0, 1);
        drive("ra1",  1, 1, 0, 1, 0, 0, 0, 0, 1);
        drive("dn0",  1, 0, 0, 1, 0, 0, 1, 0, 1);
        drive("wrap7", 1, 7, 0, 1, 0, 0, 2, 0, 1);
        drive("dn6",  1, 6, 0, 1, 0, 0, 3, 0, 1);
        drive("dn5",  1, 5, 0, 1, 0, 0, 4, 0, 1);
        drive("dn4",  1, 4, 0, 1, 0, 0, 5, 0, 1);
        drain();

        // Asynchronous reset while locked with step_cnt=5.
        chk("pre_rst.step", int'(step_cnt), 5);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive("rr2",  1, 2, 0, 0, 0, 0, 0, 0, 1);
        drive("rr3",  1, 3, 0, 0, 0, 0, 0, 0, 1);
        drive("rr4",  1, 4, 0, 1, 0, 1, 0, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
